// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scc_mem_pkg
// Brief    : Shared types and constants for the unified memory arbiter.
// Revision : 1.0
// ============================================================================
package scc_mem_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      XFER     = 3'd1,
      WAIT     = 3'd2,
      RSP      = 3'd3,
      HALT_RSP = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      K_FETCH = 2'd0,
      K_LOAD  = 2'd1,
      K_STORE = 2'd2
   } kind_e;

   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;

   // Big-endian byte select: beat 0 is bits [31:24].
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] beat);
      return w[8*(3-int'(beat)) +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_grant
// Brief    : Fetch/data grant select with anti-starvation streak counter.
// Revision : 1.0
// ============================================================================
module mem_arb_grant #(
   parameter int STREAK_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   input  logic fetch_en,
   input  logic i_req,
   input  logic d_req,
   output logic grant_fetch,
   output logic grant_data,
   output logic grant_halt
);

   localparam int               STREAK_W   = $clog2(STREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                fetch_ok;

   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      grant_halt  = 1'b0;
      fetch_ok    = i_req && fetch_en;
      if (idle) begin
         // A full streak hands one slot to the waiting fetch.
         if (d_req && !(fetch_ok && streak_q == STREAK_LIM)) begin
            grant_data = 1'b1;
         end else if (fetch_ok) begin
            grant_fetch = 1'b1;
         end else if (i_req && !fetch_en) begin
            grant_halt = 1'b1;
         end
      end

      streak_d = streak_q;
      if (grant_fetch) begin
         streak_d = '0;
      end else if (grant_data && i_req && streak_q != STREAK_LIM) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Serialises fetch and load/store words onto a byte-wide memory.
// Revision : 1.0
// ============================================================================
module unified_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int STREAK_MAX = 4
) (
   input  logic              mem_Clk,
   input  logic              mem_Rst_n,
   input  logic              fetch_en,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_valid,
   output logic [31:0]       i_data,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_we,
   output logic [7:0]        m_wdata,
   input  logic [7:0]        m_rdata,
   output logic              busy
);

   import scc_mem_pkg::*;

   localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic [1:0]        beat_q, beat_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [23:0]       rdata_q, rdata_d;
   logic [31:0]       i_data_q, i_data_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              i_valid_q, i_valid_d;
   logic              d_done_q, d_done_d;

   logic              grant_fetch, grant_data, grant_halt;
   logic [31:0]       word;

   mem_arb_grant #(
      .STREAK_MAX (STREAK_MAX)
   ) u_grant (
      .clk         (mem_Clk),
      .rst_n       (mem_Rst_n),
      .idle        (state_q == IDLE),
      .fetch_en    (fetch_en),
      .i_req       (i_req),
      .d_req       (d_req),
      .grant_fetch (grant_fetch),
      .grant_data  (grant_data),
      .grant_halt  (grant_halt)
   );

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      beat_d    = beat_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      i_data_d  = i_data_q;
      d_rdata_d = d_rdata_q;
      word      = {rdata_q, m_rdata};

      case (state_q)
         IDLE: begin
            if (grant_data) begin
               kind_d  = d_we ? K_STORE : K_LOAD;
               base_d  = d_addr;
               wdata_d = d_wdata;
               beat_d  = 2'd0;
               state_d = XFER;
            end else if (grant_fetch) begin
               kind_d  = K_FETCH;
               base_d  = i_addr;
               beat_d  = 2'd0;
               state_d = XFER;
            end else if (grant_halt) begin
               i_data_d = HALT_WORD;
               state_d  = HALT_RSP;
            end
         end
         XFER: begin
            // Read data trails the address by one cycle, so beat 0 has nothing yet.
            if (kind_q != K_STORE && beat_q != 2'd0) begin
               rdata_d = {rdata_q[15:0], m_rdata};
            end
            if (beat_q == LAST_BEAT) begin
               beat_d  = 2'd0;
               state_d = (kind_q == K_STORE) ? RSP : WAIT;
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
         WAIT: begin
            if (kind_q == K_FETCH) begin
               i_data_d = word;
            end else begin
               d_rdata_d = word;
            end
            state_d = RSP;
         end
         RSP:      state_d = IDLE;
         HALT_RSP: state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      i_valid_d = (state_d == HALT_RSP) || (state_d == RSP && kind_q == K_FETCH);
      d_done_d  = (state_d == RSP) && (kind_q != K_FETCH);
   end

   always_ff @(posedge mem_Clk or negedge mem_Rst_n) begin
      if (!mem_Rst_n) begin
         state_q   <= IDLE;
         kind_q    <= K_FETCH;
         beat_q    <= 2'd0;
         base_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         i_data_q  <= '0;
         d_rdata_q <= '0;
         i_valid_q <= 1'b0;
         d_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         i_data_q  <= i_data_d;
         d_rdata_q <= d_rdata_d;
         i_valid_q <= i_valid_d;
         d_done_q  <= d_done_d;
      end
   end

   // Memory side comes straight off registered state so reset silences it at once.
   assign m_we    = (state_q == XFER) && (kind_q == K_STORE);
   assign m_addr  = (state_q == XFER) ? base_q + {{(ADDR_W-2){1'b0}}, beat_q} : '0;
   assign m_wdata = m_we ? word_byte(wdata_q, beat_q) : 8'h00;
   assign busy    = (state_q != IDLE);
   assign i_valid = i_valid_q;
   assign d_done  = d_done_q;
   assign i_data  = i_data_q;
   assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire
